layer_conv_scheduler: RTL and testbench

LAYER_CONV_SCHEDULER -- requirements
Module: layer_conv_scheduler

---
 rtl/layer_conv_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_layer_conv_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_conv_scheduler.sv
// layer_conv_scheduler: per-layer sequencer for a Conv2D3x3 bank (weight load, pixel stream, drain).
// Optional drain watchdog is compiled in when LAYER_SCHED_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module layer_conv_scheduler #(
  parameter int IMG_SIZE       = 104,
  parameter int NUM_FMAPS      = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         start,
  input  logic                         abort,
  output logic                         wgt_req,
  input  logic                         wgt_ack,
  input  logic                         src_valid,
  output logic                         src_ready,
  output logic                         conv_valid_in,
  input  logic                         conv_valid_out,
  output logic [$clog2(IMG_SIZE)-1:0]  row,
  output logic [$clog2(IMG_SIZE)-1:0]  col,
  output logic [$clog2(NUM_FMAPS)-1:0] fmap_idx,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int POS_W       = $clog2(IMG_SIZE);
  localparam int FMAP_W      = $clog2(NUM_FMAPS);
  localparam int PIX_TOTAL_I = IMG_SIZE * IMG_SIZE;
  localparam int CNT_W       = $clog2(PIX_TOTAL_I + 1);

  localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(IMG_SIZE - 1);
  localparam logic [FMAP_W-1:0] LAST_FMAP = FMAP_W'(NUM_FMAPS - 1);
  localparam logic [CNT_W-1:0]  PIX_TOTAL = CNT_W'(PIX_TOTAL_I);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    NEXT   = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [POS_W-1:0]   row_r, row_s, col_r, col_s;
  logic [FMAP_W-1:0]  fmap_r, fmap_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               error_r, error_s;
  logic               wgt_req_r, wgt_req_s;
  logic               src_ready_r, src_ready_s;
  logic               cvi_r, cvi_s;
  logic               accept_s;
  logic               count_en_s;

`ifdef LAYER_SCHED_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_r, wd_s;
`endif

  // Next-state and next-output logic; abort overrides every other transition.
  always_comb begin
    state_s  = state_r;
    row_s    = row_r;
    col_s    = col_r;
    fmap_s   = fmap_r;
    cnt_s    = cnt_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    cvi_s    = 1'b0;
`ifdef LAYER_SCHED_TIMEOUT_EN
    error_s  = error_r;
    wd_s     = {WD_W{1'b0}};
`else
    error_s  = 1'b0;
`endif
    accept_s   = src_valid & src_ready_r;
    count_en_s = conv_valid_out & ((state_r == STREAM) | (state_r == DRAIN));

    if (abort && (state_r != IDLE)) begin
      state_s = IDLE;
      row_s   = {POS_W{1'b0}};
      col_s   = {POS_W{1'b0}};
      fmap_s  = {FMAP_W{1'b0}};
      cnt_s   = {CNT_W{1'b0}};
      busy_s  = 1'b0;
    end else begin
      // Output counter saturates so late echoes cannot wrap it.
      if (count_en_s && (cnt_r != PIX_TOTAL)) begin
        cnt_s = cnt_r + CNT_W'(1);
      end else begin
        cnt_s = cnt_r;
      end

      case (state_r)
        IDLE: begin
          if (start) begin
            state_s = LOAD_W;
            row_s   = {POS_W{1'b0}};
            col_s   = {POS_W{1'b0}};
            fmap_s  = {FMAP_W{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
            busy_s  = 1'b1;
            error_s = 1'b0;
          end else begin
            state_s = IDLE;
          end
        end
        LOAD_W: begin
          if (wgt_ack) begin
            state_s = STREAM;
          end else begin
            state_s = LOAD_W;
          end
        end
        STREAM: begin
          cvi_s = accept_s;
          if (accept_s) begin
            if (col_r == LAST_POS) begin
              col_s = {POS_W{1'b0}};
              if (row_r == LAST_POS) begin
                row_s   = {POS_W{1'b0}};
                state_s = DRAIN;
              end else begin
                row_s = row_r + POS_W'(1);
              end
            end else begin
              col_s = col_r + POS_W'(1);
            end
          end else begin
            state_s = STREAM;
          end
        end
        DRAIN: begin
          if (cnt_r == PIX_TOTAL) begin
            state_s = NEXT;
          end else begin
`ifdef LAYER_SCHED_TIMEOUT_EN
            if (conv_valid_out) begin
              wd_s = {WD_W{1'b0}};
            end else if (wd_r == WD_LAST) begin
              error_s = 1'b1;
              busy_s  = 1'b0;
              state_s = IDLE;
            end else begin
              wd_s = wd_r + WD_W'(1);
            end
`else
            state_s = DRAIN;
`endif
          end
        end
        NEXT: begin
          cnt_s = {CNT_W{1'b0}};
          if (fmap_r == LAST_FMAP) begin
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = IDLE;
          end else begin
            fmap_s  = fmap_r + FMAP_W'(1);
            state_s = LOAD_W;
          end
        end
        default: begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      endcase
    end

    wgt_req_s   = (state_s == LOAD_W);
    src_ready_s = (state_s == STREAM);
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r     <= IDLE;
      row_r       <= {POS_W{1'b0}};
      col_r       <= {POS_W{1'b0}};
      fmap_r      <= {FMAP_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      wgt_req_r   <= 1'b0;
      src_ready_r <= 1'b0;
      cvi_r       <= 1'b0;
`ifdef LAYER_SCHED_TIMEOUT_EN
      wd_r        <= {WD_W{1'b0}};
`endif
    end else begin
      state_r     <= state_s;
      row_r       <= row_s;
      col_r       <= col_s;
      fmap_r      <= fmap_s;
      cnt_r       <= cnt_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      error_r     <= error_s;
      wgt_req_r   <= wgt_req_s;
      src_ready_r <= src_ready_s;
      cvi_r       <= cvi_s;
`ifdef LAYER_SCHED_TIMEOUT_EN
      wd_r        <= wd_s;
`endif
    end
  end

  assign wgt_req       = wgt_req_r;
  assign src_ready     = src_ready_r;
  assign conv_valid_in = cvi_r;
  assign row           = row_r;
  assign col           = col_r;
  assign fmap_idx      = fmap_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;

endmodule

// File: tb/tb_layer_conv_scheduler.sv
// Directed bench for layer_conv_scheduler: 4x4 image, 2 fmaps, bank echo latency 5.
`timescale 1ns/1ps
module tb_layer_conv_scheduler;
  localparam int IMG = 4;
  localparam int NF  = 2;
  localparam int TO  = 8;

  logic Clk = 1'b0, Rst = 1'b0, start = 1'b0, abort = 1'b0, wgt_ack = 1'b0, src_valid = 1'b0;
  logic conv_valid_out, wgt_req, src_ready, conv_valid_in, busy, done, error;
  logic [1:0] row, col;
  logic [0:0] fmap_idx;

  layer_conv_scheduler #(.IMG_SIZE(IMG), .NUM_FMAPS(NF), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .abort(abort),
    .wgt_req(wgt_req), .wgt_ack(wgt_ack), .src_valid(src_valid), .src_ready(src_ready),
    .conv_valid_in(conv_valid_in), .conv_valid_out(conv_valid_out),
    .row(row), .col(col), .fmap_idx(fmap_idx), .busy(busy), .done(done), .error(error));

  always #5 Clk = ~Clk;

  // Bank model: echo valid with latency 5, optionally withholding the 16th output.
  logic [4:0] pipe = 5'd0;
  int  bank_cnt = 0;
  bit  bank_clr = 1'b0;
  bit  block_mode = 1'b0;
  always @(posedge Clk) begin
    pipe <= {pipe[3:0], conv_valid_in};
    if (bank_clr) bank_cnt <= 0;
    else if (pipe[4]) bank_cnt <= bank_cnt + 1;
  end
  assign conv_valid_out = pipe[4] && !(block_mode && bank_cnt == 15);

  int n_pass = 0, n_total = 0, cyc = 0;
  int n_wreq, n_done, cvi0, cvi1, n_acc, pix, wreq_age, n_stray, last_cvo_cyc, err_cyc;
  int abort_at = -1;
  bit wreq_prev, acc_pend = 1'b0, start_req = 1'b0, toggle_mode = 1'b0, stray_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic clear_stats();
    n_wreq = 0; n_done = 0; cvi0 = 0; cvi1 = 0; n_acc = 0; pix = 0;
    wreq_age = 0; wreq_prev = 1'b0; n_stray = 0; last_cvo_cyc = -1; err_cyc = -1;
    bank_clr = 1'b1;
  endtask

  // One cycle: observe at negedge, then drive the next inputs.
  task automatic step();
    bit stray;
    @(negedge Clk);
    cyc++;
    bank_clr = 1'b0;
    check("cvi_vs_accept", conv_valid_in, acc_pend);
    if (conv_valid_in) begin
      if (fmap_idx == 1'b0) cvi0++; else cvi1++;
    end
    if (done) n_done++;
    if (conv_valid_out) last_cvo_cyc = cyc;
    if (error && err_cyc < 0) err_cyc = cyc;
    if (wgt_req) wreq_age++; else wreq_age = 0;
    if (wgt_req && !wreq_prev) n_wreq++;
    wreq_prev = wgt_req;
    stray = stray_mode && src_ready && (pix == 3);
    if (stray) n_stray++;
    start = start_req || stray;
    start_req = 1'b0;
    wgt_ack = (wreq_age == 3) || stray;
    src_valid = toggle_mode ? !src_valid : 1'b1;
    abort = 1'b0;
    if (src_ready && src_valid) begin
      check("row", row, pix / IMG);
      check("col", col, pix % IMG);
      if (n_acc == abort_at - 1) abort = 1'b1;
      pix = (pix + 1) % (IMG * IMG);
      n_acc++;
    end
    acc_pend = src_ready && src_valid && !abort;
  endtask

  task automatic run_layer(input int budget);
    start_req = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (n_done != 0) break;
    end
    repeat (8) step();
  endtask

  task automatic check_layer(input string t);
    check({t, "_done_pulses"}, n_done, 1);
    check({t, "_busy_after"}, busy, 0);
    check({t, "_wgt_req_phases"}, n_wreq, 2);
    check({t, "_cvi_fmap0"}, cvi0, 16);
    check({t, "_cvi_fmap1"}, cvi1, 16);
    check({t, "_accepts"}, n_acc, 32);
    check({t, "_src_ready_after"}, src_ready, 0);
    check({t, "_error"}, error, 0);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    check("reset_outputs", {wgt_req, src_ready, conv_valid_in, busy, done, error, row, col, fmap_idx}, 0);
    Rst = 1'b1;
    repeat (3) step();
    check("idle_busy", busy, 0);

    // Plain two-fmap layer
    clear_stats();
    run_layer(400);
    check_layer("basic");

    // Stray start and wgt_ack while streaming
    stray_mode = 1'b1;
    clear_stats();
    run_layer(400);
    check_layer("stray");
    check("stray_injected", n_stray, 2);
    stray_mode = 1'b0;

    // Source valid toggling every cycle
    toggle_mode = 1'b1;
    clear_stats();
    run_layer(400);
    check_layer("toggle");
    toggle_mode = 1'b0;

    // Abort on the 7th accepted pixel (row 1, col 2)
    abort_at = 7;
    clear_stats();
    start_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (n_acc >= 7) break;
    end
    check("abort_reached", n_acc, 7);
    step();
    abort_at = -1;
    check("abort_row", row, 0);
    check("abort_col", col, 0);
    check("abort_fmap", fmap_idx, 0);
    check("abort_src_ready", src_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_wgt_req", wgt_req, 0);
    repeat (10) step();
    check("abort_no_done", n_done, 0);
    clear_stats();
    run_layer(400);
    check_layer("after_abort");

    // Asynchronous reset mid-stream
    clear_stats();
    start_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (n_acc >= 5) break;
    end
    check("pre_reset_src_ready", src_ready, 1);
    #2 Rst = 1'b0;
    #1;
    check("async_reset_outputs", {wgt_req, src_ready, conv_valid_in, busy, done, error, row, col, fmap_idx}, 0);
    @(negedge Clk);
    Rst = 1'b1;
    acc_pend = 1'b0;
    repeat (8) step();
    check("post_reset_idle_busy", busy, 0);
    check("post_reset_idle_wgt_req", wgt_req, 0);
    clear_stats();
    run_layer(400);
    check_layer("after_reset");

    // Bank withholds the 16th output of fmap 0
    block_mode = 1'b1;
    clear_stats();
    start_req = 1'b1;
    for (int i = 0; i < 150; i++) begin
      step();
`ifdef LAYER_SCHED_TIMEOUT_EN
      if (err_cyc >= 0) break;
`endif
    end
`ifdef LAYER_SCHED_TIMEOUT_EN
    check("wd_error", error, 1);
    check("wd_latency", err_cyc - last_cvo_cyc, 9);
    check("wd_busy", busy, 0);
    check("wd_src_ready", src_ready, 0);
    check("wd_no_done", n_done, 0);
`else
    check("stuck_error", error, 0);
    check("stuck_busy", busy, 1);
    check("stuck_src_ready", src_ready, 0);
    check("stuck_wgt_req", wgt_req, 0);
    check("stuck_fmap", fmap_idx, 0);
    check("stuck_no_done", n_done, 0);
`endif
    block_mode = 1'b0;
    abort = 1'b1;
    step();
    repeat (8) step();
    check("exit_busy", busy, 0);
    clear_stats();
    start_req = 1'b1;
    repeat (2) step();
    check("restart_error_clear", error, 0);
    check("restart_busy", busy, 1);
    abort = 1'b1;
    step();
    repeat (8) step();
    check("final_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
